rr_merge_21: RTL and testbench

- Two-input round-robin stream merger that sits directly upstream of the 2:1 mux datapath.
- Arbitrates between two valid/ready producers and produces the select (J-equivalent) for the mux.
- Holds the chosen beat in a one-entry output register, so the consumer sees a registered, stable stream.
- Gives fair 1-beat-per-cycle merging with back-pressure, replacing a free-running combinational select.

---
 rtl/rr_merge_21.sv | 75 +++++++
 tb/tb_rr_merge_21.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rr_merge_21.sv
// rr_merge_21: two-input round-robin merger into a one-entry registered output stage.
// Define RR_MERGE_21_GNTCNT_EN to add saturating per-source grant counters gnt_cnt0/gnt_cnt1.
module rr_merge_21 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             out_sel
`ifdef RR_MERGE_21_GNTCNT_EN
  ,
  output logic [15:0]      gnt_cnt0,
  output logic [15:0]      gnt_cnt1
`endif
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sel_q, sel_d, prio_q, prio_d;
  logic             load_en, any_v, grant, fire;
  always_comb begin
    load_en   = (state_q == EMPTY) || out_ready;
    any_v     = in0_valid || in1_valid;
    grant     = (in0_valid && in1_valid) ? prio_q : in1_valid;
    fire      = !rst && load_en && any_v;
    in0_ready = fire && !grant;
    in1_ready = fire && grant;
    state_d   = load_en ? (any_v ? FULL : EMPTY) : state_q;
    data_d    = fire ? (grant ? in1_data : in0_data) : data_q;
    sel_d     = fire ? grant : sel_q;
    prio_d    = fire ? !grant : prio_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
    end
  end
  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;
`ifdef RR_MERGE_21_GNTCNT_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  always_comb begin
    cnt0_d = (in0_ready && cnt0_q != 16'hFFFF) ? cnt0_q + 16'd1 : cnt0_q;
    cnt1_d = (in1_ready && cnt1_q != 16'hFFFF) ? cnt1_q + 16'd1 : cnt1_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end
  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_rr_merge_21.sv
// tb_rr_merge_21: directed vector table, random traffic against a reference model, counter sequences.
module tb_rr_merge_21;
  logic       clk = 1'b0;
  logic       rst, in0_valid, in1_valid, out_ready;
  logic [7:0] in0_data, in1_data;
  logic       in0_ready, in1_ready, out_valid, out_sel;
  logic [7:0] out_data;
`ifdef RR_MERGE_21_GNTCNT_EN
  logic [15:0] gnt_cnt0, gnt_cnt1;
`endif
  rr_merge_21 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_sel(out_sel)
`ifdef RR_MERGE_21_GNTCNT_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst, v0; logic [7:0] d0; logic v1; logic [7:0] d1; logic ordy;
    logic r0, r1, ov; logic [7:0] od; logic sel;
  } vec_t;
  vec_t vecs[24];
  int checks = 0;
  int errors = 0;
  // Reference model state: the held beat, who wins the next tie, handshake totals.
  logic m_valid, m_sel, m_prio;
  logic [7:0] m_data;
  int m_cnt0, m_cnt1;
  function automatic vec_t mv(input logic rs, v0, input logic [7:0] d0, input logic v1,
                              input logic [7:0] d1, input logic ordy, r0, r1, ov,
                              input logic [7:0] od, input logic sel);
    vec_t v;
    v.rst = rs; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.ordy = ordy;
    v.r0 = r0; v.r1 = r1; v.ov = ov; v.od = od; v.sel = sel;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic drive(input logic rs, v0, input logic [7:0] d0, input logic v1,
                       input logic [7:0] d1, input logic ordy);
    rst = rs; in0_valid = v0; in0_data = d0; in1_valid = v1; in1_data = d1; out_ready = ordy;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic mr(input int n);
    logic room, win;
    room = !m_valid || out_ready;
    win  = (in0_valid && in1_valid) ? m_prio : in1_valid;
    return !rst && room && (in0_valid || in1_valid) && (win == n[0]);
  endfunction
  task automatic model_edge();
    logic g0, g1;
    g0 = mr(0);
    g1 = mr(1);
    if (rst) begin
      m_valid = 0; m_data = 0; m_sel = 0; m_prio = 0; m_cnt0 = 0; m_cnt1 = 0;
    end else if (g0 || g1) begin
      m_valid = 1; m_data = g1 ? in1_data : in0_data; m_sel = g1; m_prio = !g1;
      if (g0 && m_cnt0 < 65535) m_cnt0++;
      if (g1 && m_cnt1 < 65535) m_cnt1++;
    end else if (!m_valid || out_ready) begin
      m_valid = 0;
    end
  endtask
  initial begin
    logic acc0, acc1, e0, e1;
    vecs[0]  = mv(1,1,8'hA0,1,8'hB1,1, 0,0,0,8'h00,0);
    vecs[1]  = mv(1,1,8'hA0,1,8'hB1,1, 0,0,0,8'h00,0);
    vecs[2]  = mv(0,1,8'hA0,1,8'hB1,1, 1,0,1,8'hA0,0);
    vecs[3]  = mv(0,1,8'hA0,1,8'hB1,1, 0,1,1,8'hB1,1);
    vecs[4]  = mv(0,1,8'hA0,1,8'hB1,1, 1,0,1,8'hA0,0);
    vecs[5]  = mv(0,1,8'hA0,1,8'hB1,1, 0,1,1,8'hB1,1);
    vecs[6]  = mv(0,1,8'hA0,1,8'hB1,1, 1,0,1,8'hA0,0);
    vecs[7]  = mv(0,1,8'hA0,1,8'hB1,1, 0,1,1,8'hB1,1);
    vecs[8]  = mv(0,1,8'h5A,1,8'hC3,1, 1,0,1,8'h5A,0);
    vecs[9]  = mv(0,1,8'h66,1,8'hC3,0, 0,0,1,8'h5A,0);
    vecs[10] = mv(0,1,8'h66,1,8'hC3,0, 0,0,1,8'h5A,0);
    vecs[11] = mv(0,1,8'h66,1,8'hC3,0, 0,0,1,8'h5A,0);
    vecs[12] = mv(0,1,8'h66,1,8'hC3,1, 0,1,1,8'hC3,1);
    vecs[13] = mv(0,0,8'h00,1,8'h01,1, 0,1,1,8'h01,1);
    vecs[14] = mv(0,0,8'h00,1,8'h02,1, 0,1,1,8'h02,1);
    vecs[15] = mv(0,0,8'h00,1,8'h03,1, 0,1,1,8'h03,1);
    vecs[16] = mv(0,0,8'h00,1,8'h04,1, 0,1,1,8'h04,1);
    vecs[17] = mv(0,1,8'hA0,1,8'hB1,1, 1,0,1,8'hA0,0);
    vecs[18] = mv(0,1,8'h33,0,8'h00,1, 1,0,1,8'h33,0);
    vecs[19] = mv(0,0,8'h00,0,8'h00,1, 0,0,0,8'h33,0);
    vecs[20] = mv(0,0,8'h00,0,8'h00,1, 0,0,0,8'h33,0);
    vecs[21] = mv(0,1,8'h44,0,8'h00,0, 1,0,1,8'h44,0);
    vecs[22] = mv(1,1,8'h55,1,8'h66,0, 0,0,0,8'h00,0);
    vecs[23] = mv(0,1,8'h55,1,8'h66,1, 1,0,1,8'h55,0);
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].rst, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].ordy);
      #1;
      chk($sformatf("vec%0d in0_ready", i), in0_ready, vecs[i].r0);
      chk($sformatf("vec%0d in1_ready", i), in1_ready, vecs[i].r1);
      tick();
      chk($sformatf("vec%0d out_valid", i), out_valid, vecs[i].ov);
      chk($sformatf("vec%0d out_data", i), out_data, vecs[i].od);
      chk($sformatf("vec%0d out_sel", i), out_sel, vecs[i].sel);
    end
    acc0 = 1; acc1 = 1;
    for (int i = 0; i < 3000; i++) begin
      rst = (i == 0) || ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in0_valid || acc0) begin in0_valid = ($urandom_range(0, 2) != 0); in0_data = 8'($urandom); end
      if (!in1_valid || acc1) begin in1_valid = ($urandom_range(0, 2) != 0); in1_data = 8'($urandom); end
      #1;
      if (i > 0) begin
        e0 = mr(0);
        e1 = mr(1);
        chk("rand in0_ready", in0_ready, e0);
        chk("rand in1_ready", in1_ready, e1);
      end
      acc0 = (i > 0) && mr(0);
      acc1 = (i > 0) && mr(1);
      tick();
      model_edge();
      chk("rand out_valid", out_valid, m_valid);
      if (m_valid) chk("rand out_data", out_data, m_data);
      if (m_valid) chk("rand out_sel", out_sel, m_sel);
`ifdef RR_MERGE_21_GNTCNT_EN
      chk("rand gnt_cnt0", gnt_cnt0, m_cnt0);
      chk("rand gnt_cnt1", gnt_cnt1, m_cnt1);
`endif
    end
`ifdef RR_MERGE_21_GNTCNT_EN
    drive(1,0,0,0,0,1);
    tick();
    for (int i = 0; i < 6; i++) begin drive(0,1,8'h10,1,8'h20,1); tick(); end
    for (int i = 0; i < 2; i++) begin drive(0,1,8'h11,0,8'h00,1); tick(); end
    chk("cnt0 before rst", gnt_cnt0, 5);
    chk("cnt1 before rst", gnt_cnt1, 3);
    drive(1,1,8'h12,1,8'h21,1);
    tick();
    chk("cnt0 after rst", gnt_cnt0, 0);
    chk("cnt1 after rst", gnt_cnt1, 0);
    chk("out_valid after rst", out_valid, 0);
    drive(0,1,8'h77,0,8'h00,1);
    for (int i = 0; i < 65540; i++) tick();
    chk("cnt0 saturated", gnt_cnt0, 16'hFFFF);
    chk("cnt1 idle", gnt_cnt1, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
